// File: rtl/arith_pipe_unit.sv
// arith_pipe_unit: elastic add/sub/min/max pipeline with tag pass-through and saturating overflow counter.
// Define ARITH_PIPE_SAT_EN to clamp add/sub results on carry/borrow instead of wrapping.
module arith_pipe_unit #(
  parameter int W     = 10,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt
);
  logic [W:0]       sum, dif;
  logic [W-1:0]     sum_y, dif_y, res;
  logic             res_ovf;
  logic [DEPTH-1:0] v, o, adv, nv, no;
  logic [W-1:0]     ys [DEPTH];
  logic [W-1:0]     ny [DEPTH];
  logic [TAG_W-1:0] ts [DEPTH];
  logic [TAG_W-1:0] nt [DEPTH];

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
`ifdef ARITH_PIPE_SAT_EN
  assign sum_y = sum[W] ? '1 : sum[W-1:0];
  assign dif_y = dif[W] ? '0 : dif[W-1:0];
`else
  assign sum_y = sum[W-1:0];
  assign dif_y = dif[W-1:0];
`endif
  assign res = op == 2'b00 ? sum_y :
               op == 2'b01 ? dif_y :
               op == 2'b10 ? (b < a ? b : a) : (b > a ? b : a);
  assign res_ovf = op == 2'b00 ? sum[W] : op == 2'b01 ? dif[W] : 1'b0;

  // stage k may advance if any stage at or beyond k is empty, or the consumer takes the head
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++)
      adv[k] = out_ready | ~&(v | DEPTH'((1 << k) - 1));
  end

  always_comb begin
    nv    = '0;
    no    = '0;
    nv[0] = in_valid;
    no[0] = res_ovf;
    ny[0] = res;
    nt[0] = in_tag;
    for (int k = 1; k < DEPTH; k++) begin
      nv[k] = v[k-1];
      no[k] = o[k-1];
      ny[k] = ys[k-1];
      nt[k] = ts[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      o <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ys[k] <= '0;
        ts[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (adv[k]) begin
          v[k]  <= nv[k];
          o[k]  <= no[k];
          ys[k] <= ny[k];
          ts[k] <= nt[k];
        end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_cnt <= '0;
    else if (clr_cnt) ovf_cnt <= '0;
    else if (out_valid && out_ready && ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign ovf       = o[DEPTH-1];
  assign y         = ys[DEPTH-1];
  assign out_tag   = ts[DEPTH-1];
endmodule

// File: tb/tb_arith_pipe_unit.sv
// tb_arith_pipe_unit: scoreboard bench for arith_pipe_unit at W=10, DEPTH=2, TAG_W=4, CNT_W=8.
module tb_arith_pipe_unit;
  localparam int W = 10, DEPTH = 2, TAG_W = 4, CNT_W = 8;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, clr_cnt = 0;
  logic in_ready, out_valid, ovf;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, y;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  logic [CNT_W-1:0] ovf_cnt;

  typedef struct packed {
    logic [W-1:0]     y;
    logic             o;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t sb [$];
  int   acc_cyc [$];
  int   n_vec = 0, n_bad = 0, cyc = 0, n_acc = 0, n_out = 0, n_block = 0;
  logic acc_flag = 0, chk_lat = 1;

  arith_pipe_unit #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .out_tag(out_tag), .ovf_cnt(ovf_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] f, input int x, input int z, input logic [TAG_W-1:0] t);
    int r;
    exp_t e;
    e.t = t;
    e.o = 0;
    case (f)
      2'd0: begin
        r = x + z;
        e.o = r > 1023;
`ifdef ARITH_PIPE_SAT_EN
        if (e.o) r = 1023;
`else
        if (e.o) r = r - 1024;
`endif
      end
      2'd1: begin
        r = x - z;
        e.o = r < 0;
`ifdef ARITH_PIPE_SAT_EN
        if (e.o) r = 0;
`else
        if (e.o) r = r + 1024;
`endif
      end
      2'd2: r = x < z ? x : z;
      default: r = x > z ? x : z;
    endcase
    e.y = W'(r);
    return e;
  endfunction

  // sample one time unit before each rising edge: the transfers seen here happen at that edge
  always begin
    @(negedge clk);
    #4;
    cyc++;
    acc_flag = rst_n && in_valid && in_ready;
    if (rst_n) begin
      if (in_valid && !in_ready) n_block++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("y", 32'(y), 32'(e.y));
          check("ovf", 32'(ovf), 32'(e.o));
          check("tag", 32'(out_tag), 32'(e.t));
          if (chk_lat) check("latency", cyc - acc_cyc[0], DEPTH);
          void'(acc_cyc.pop_front());
          n_out++;
        end
      end
      if (acc_flag) begin
        sb.push_back(model(op, int'(a), int'(b), in_tag));
        acc_cyc.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [1:0] f, input int x, input int z, input int t);
    @(negedge clk);
    in_valid = 1;
    op = f;
    a = W'(x);
    b = W'(z);
    in_tag = TAG_W'(t);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (acc_flag) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, blk;
    logic [W-1:0] hy;
    logic [TAG_W-1:0] ht;
    #23;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    send(2'd0, 3, 4, 5);
    drain();
    send(2'd0, 1000, 100, 6);
    drain();
    check("ovf_cnt_1", 32'(ovf_cnt), 1);
    send(2'd1, 5, 9, 7);
    drain();
    check("ovf_cnt_2", 32'(ovf_cnt), 2);

    base = n_out;
    blk = n_block;
    send(2'd2, 200, 17, 1);
    send(2'd3, 200, 17, 2);
    send(2'd2, 17, 200, 3);
    send(2'd3, 17, 200, 4);
    send(2'd0, 511, 512, 8);
    send(2'd1, 900, 900, 9);
    send(2'd2, 33, 33, 10);
    send(2'd1, 1023, 1, 11);
    drain();
    check("b2b_count", n_out - base, 8);
    check("b2b_in_ready_low", n_block - blk, 0);
    check("ovf_cnt_b2b", 32'(ovf_cnt), 2);

    chk_lat = 0;
    out_ready = 0;
    base = n_acc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1;
      op = 2'd0;
      a = W'(i * 10);
      b = 1;
      in_tag = TAG_W'(i + 1);
    end
    #1;
    check("stall_accepted", n_acc - base, DEPTH);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_out_valid", 32'(out_valid), 1);
    hy = y;
    ht = out_tag;
    repeat (3) @(negedge clk);
    #1;
    check("stall_y_stable", 32'(y), 32'(hy));
    check("stall_tag_stable", 32'(out_tag), 32'(ht));
    base = n_out;
    in_valid = 0;
    out_ready = 1;
    drain();
    check("stall_delivered", n_out - base, DEPTH);
    check("stall_sb_empty", sb.size(), 0);
    chk_lat = 1;

    for (int i = 0; i < 253; i++) send(2'd0, 1000, 100, i);
    drain();
    check("ovf_cnt_255", 32'(ovf_cnt), 255);
    for (int i = 0; i < 3; i++) send(2'd1, 0, 1, i);
    drain();
    check("ovf_cnt_sat", 32'(ovf_cnt), 255);

    chk_lat = 0;
    out_ready = 0;
    send(2'd0, 1000, 100, 12);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    check("clr_head_valid", 32'(out_valid), 1);
    base = n_out;
    out_ready = 1;
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    check("clr_transfer", n_out - base, 1);
    check("clr_priority", 32'(ovf_cnt), 0);

    out_ready = 0;
    send(2'd0, 1, 2, 13);
    send(2'd0, 1000, 100, 14);
    @(negedge clk);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_y", 32'(y), 0);
    check("async_rst_ovf_cnt", 32'(ovf_cnt), 0);
    sb.delete();
    acc_cyc.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    base = n_out;
    repeat (5) @(negedge clk);
    check("no_ghost_results", n_out - base, 0);
    check("post_rst_out_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
